// File: rtl/i2c_txn_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C transaction arbiter: descriptor field widths,
// the WAIT_BUSY limit, the sequencer state encoding and a small helper that
// steers the byte count onto the tx or rx count of the engine.
// Ports: none (package).
// ----------------------------------------------------------------------------
package i2c_arb_pkg;

  localparam int DEV_W = 10;
  localparam int REG_W = 16;
  localparam int CNT_W = 8;

  // Cycles spent in WAIT_BUSY looking for eng_busy before giving up.
  localparam logic [2:0] BUSY_WAIT_LIMIT = 3'd4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;
  localparam logic [2:0] S_DRAIN     = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_LOAD      = S_LOAD,
    ST_START     = S_START,
    ST_WAIT_BUSY = S_WAIT_BUSY,
    ST_WAIT_DONE = S_WAIT_DONE,
    ST_RESP      = S_RESP,
    ST_DRAIN     = S_DRAIN
  } arb_state_e;

  // Returns the byte count when the transfer direction matches the counter
  // being loaded, zero otherwise (a read loads rx_count, a write tx_count).
  function automatic logic [CNT_W-1:0] dir_count(input logic is_read,
                                                 input logic want_read,
                                                 input logic [CNT_W-1:0] count);
    return (is_read == want_read) ? count : {CNT_W{1'b0}};
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// ----------------------------------------------------------------------------
// i2c_txn_arbiter_if
// Client-side request/response bundle of the I2C transaction arbiter.
// Ports (signals): req_valid/req_ready handshake, per-client descriptor
// (req_rw, req_10bit, req_dev_addr, req_reg_addr, req_reg_addr_len,
// req_count) and the one-hot response rsp_valid with rsp_ack_error and
// rsp_timeout. Client i occupies slice i of every packed field.
// Modports: master = clients, slave = arbiter.
// ----------------------------------------------------------------------------
interface i2c_txn_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_rw;
  logic [NUM_REQ-1:0]       req_10bit;
  logic [NUM_REQ*DEV_W-1:0] req_dev_addr;
  logic [NUM_REQ*REG_W-1:0] req_reg_addr;
  logic [NUM_REQ-1:0]       req_reg_addr_len;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     rsp_ack_error;
  logic                     rsp_timeout;

  modport master (
    output req_valid, req_rw, req_10bit, req_dev_addr, req_reg_addr,
           req_reg_addr_len, req_count,
    input  req_ready, rsp_valid, rsp_ack_error, rsp_timeout
  );

  modport slave (
    input  req_valid, req_rw, req_10bit, req_dev_addr, req_reg_addr,
           req_reg_addr_len, req_count,
    output req_ready, rsp_valid, rsp_ack_error, rsp_timeout
  );
endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker. Search starts at last_grant+1
// (mod NUM_REQ) and wraps; the first requesting client wins.
// Ports: req (request vector), last_grant (previous winner index),
//        grant (one-hot winner), grant_idx (winner index), any_grant.
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Rotating priority search: first requester after last_grant wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s        = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      hit_s         = !any_grant && req[cand_s];
      grant[cand_s] = hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      any_grant     = any_grant | hit_s;
    end
  end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_txn_arbiter
// Grants the shared I2C engine round-robin to NUM_REQ clients, loads the
// winner's descriptor into the engine configuration, issues one start pulse,
// waits for completion and returns a one-hot response with ACK-error and
// timeout status. All outputs are registered; reset is synchronous.
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog of
// TIMEOUT_CYCLES clocks (otherwise rsp_timeout stays 0 and WAIT_DONE waits
// forever).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cli (slave modport)      client request/response bundle
//   grant_id, arb_busy       current owner (valid while busy), in-flight flag
//   eng_enable, eng_10bit_addr, eng_reg_addr_len, eng_dev_addr,
//   eng_reg_addr, eng_tx_count, eng_rx_count   engine configuration
//   eng_tx_start, eng_rx_start                 engine start pulses
//   eng_busy, eng_done, eng_ack_error          engine status
// ----------------------------------------------------------------------------
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  i2c_txn_arbiter_if.slave           cli,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       eng_enable,
  output logic                       eng_10bit_addr,
  output logic                       eng_reg_addr_len,
  output logic [DEV_W-1:0]           eng_dev_addr,
  output logic [REG_W-1:0]           eng_reg_addr,
  output logic [CNT_W-1:0]           eng_tx_count,
  output logic [CNT_W-1:0]           eng_rx_count,
  output logic                       eng_tx_start,
  output logic                       eng_rx_start,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  input  logic                       eng_ack_error
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_r, state_nxt_s;
  logic [IDX_W-1:0]   last_grant_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               any_s, accept_s;
  logic               rw_r;
  logic [2:0]         wb_cnt_r;
  logic               err_nxt_s, tout_nxt_s;
  logic [NUM_REQ-1:0] req_ready_r, rsp_valid_r;
  logic               rsp_ack_error_r, rsp_timeout_r;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (cli.req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s),
    .any_grant  (any_s)
  );

  assign accept_s          = (state_r == ST_IDLE) && any_s;
  assign cli.req_ready     = req_ready_r;
  assign cli.rsp_valid     = rsp_valid_r;
  assign cli.rsp_ack_error = rsp_ack_error_r;
  assign cli.rsp_timeout   = rsp_timeout_r;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] to_cnt_r;

  // Watchdog: counts cycles spent in WAIT_DONE, cleared on leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= 32'd0;
    end else if (state_r == ST_WAIT_DONE && state_nxt_s == ST_WAIT_DONE) begin
      to_cnt_r <= to_cnt_r + 32'd1;
    end else begin
      to_cnt_r <= 32'd0;
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state logic and the status carried into RESP.
  always_comb begin
    state_nxt_s = state_r;
    err_nxt_s   = 1'b0;
    tout_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD:  state_nxt_s = ST_START;
      ST_START: state_nxt_s = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (eng_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (wb_cnt_r == BUSY_WAIT_LIMIT) begin
          // Engine never picked up the start: report as an ACK error.
          state_nxt_s = ST_RESP;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (eng_done) begin
          // eng_ack_error is only meaningful in the eng_done cycle.
          state_nxt_s = ST_RESP;
          err_nxt_s   = eng_ack_error;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (to_cnt_r == 32'(TIMEOUT_CYCLES - 1)) begin
          state_nxt_s = ST_RESP;
          tout_nxt_s  = 1'b1;
        end
`endif
        else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_RESP: state_nxt_s = ST_DRAIN;
      ST_DRAIN: begin
        if (!eng_busy) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Busy-wait counter: restarts at 0 every time WAIT_BUSY is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cnt_r <= 3'd0;
    end else if (state_r == ST_WAIT_BUSY && state_nxt_s == ST_WAIT_BUSY) begin
      wb_cnt_r <= wb_cnt_r + 3'd1;
    end else begin
      wb_cnt_r <= 3'd0;
    end
  end

  // Descriptor capture on accept; config is then held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r     <= IDX_W'(NUM_REQ - 1);
      grant_id         <= '0;
      rw_r             <= 1'b0;
      eng_enable       <= 1'b0;
      eng_10bit_addr   <= 1'b0;
      eng_reg_addr_len <= 1'b0;
      eng_dev_addr     <= '0;
      eng_reg_addr     <= '0;
      eng_tx_count     <= '0;
      eng_rx_count     <= '0;
    end else if (accept_s) begin
      last_grant_r     <= grant_idx_s;
      grant_id         <= grant_idx_s;
      rw_r             <= cli.req_rw[grant_idx_s];
      eng_enable       <= 1'b1;
      eng_10bit_addr   <= cli.req_10bit[grant_idx_s];
      eng_reg_addr_len <= cli.req_reg_addr_len[grant_idx_s];
      eng_dev_addr     <= cli.req_dev_addr[grant_idx_s*DEV_W +: DEV_W];
      eng_reg_addr     <= cli.req_reg_addr[grant_idx_s*REG_W +: REG_W];
      eng_tx_count     <= dir_count(cli.req_rw[grant_idx_s], 1'b0,
                                    cli.req_count[grant_idx_s*CNT_W +: CNT_W]);
      eng_rx_count     <= dir_count(cli.req_rw[grant_idx_s], 1'b1,
                                    cli.req_count[grant_idx_s*CNT_W +: CNT_W]);
    end else if (state_nxt_s == ST_IDLE || tout_nxt_s) begin
      // A watchdog expiry drops enable so the engine abandons the transfer.
      eng_enable <= 1'b0;
    end
  end

  // Single-cycle pulses and busy flag, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r     <= '0;
      rsp_valid_r     <= '0;
      rsp_ack_error_r <= 1'b0;
      rsp_timeout_r   <= 1'b0;
      eng_tx_start    <= 1'b0;
      eng_rx_start    <= 1'b0;
      arb_busy        <= 1'b0;
    end else begin
      req_ready_r     <= accept_s ? grant_s : '0;
      rsp_valid_r     <= (state_nxt_s == ST_RESP) ? (ONE_HOT0 << grant_id) : '0;
      rsp_ack_error_r <= (state_nxt_s == ST_RESP) && err_nxt_s;
      rsp_timeout_r   <= (state_nxt_s == ST_RESP) && tout_nxt_s;
      eng_tx_start    <= (state_nxt_s == ST_START) && !rw_r;
      eng_rx_start    <= (state_nxt_s == ST_START) && rw_r;
      arb_busy        <= (state_nxt_s != ST_IDLE);
    end
  end
endmodule
